// File: rtl/grid_ram_arbiter_pkg.sv
// Shared types and defaults for the grid RAM arbiter.
package grid_pkg;

    localparam int unsigned DEF_ADDR_W = 24;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_RUN  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_ENG  = 2'd2
    } owner_t;

endpackage

// File: rtl/grid_ram_arbiter_if.sv
// Requester, mode-control and RAM signals seen by the grid RAM arbiter.
interface grid_ram_arbiter_if #(
    parameter int unsigned ADDR_W = grid_pkg::DEF_ADDR_W
);
    logic              load_start;
    logic              load_done;
    logic              run_en;
    logic [1:0]        mode;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic              disp_rdata;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_wdata;
    logic              ld_gnt;

    logic              eng_req;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_wdata;
    logic              eng_gnt;
    logic              eng_rvalid;
    logic              eng_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic              ram_rden;
    logic              ram_wren;
    logic              ram_write_data;
    logic              ram_read_data;

    // Arbiter side
    modport slave (
        input  load_start, load_done, run_en,
        output mode,
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rdata,
        input  ld_req, ld_addr, ld_wdata,
        output ld_gnt,
        input  eng_req, eng_we, eng_addr, eng_wdata,
        output eng_gnt, eng_rvalid, eng_rdata,
        output ram_address, ram_rden, ram_wren, ram_write_data,
        input  ram_read_data
    );

    // Requesters and RAM side
    modport master (
        output load_start, load_done, run_en,
        input  mode,
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rdata,
        output ld_req, ld_addr, ld_wdata,
        input  ld_gnt,
        output eng_req, eng_we, eng_addr, eng_wdata,
        input  eng_gnt, eng_rvalid, eng_rdata,
        input  ram_address, ram_rden, ram_wren, ram_write_data,
        output ram_read_data
    );

endinterface

// File: rtl/grid_ram_arbiter_return_pipe.sv
// Tracks the owner of each issued read and steers RAM read data back to it.
module ram_return_pipe
    import grid_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic   clk_ram,
    input  logic   reset,
    input  owner_t i_tag,
    input  logic   i_rdata,
    output logic   o_disp_rvalid,
    output logic   o_disp_rdata,
    output logic   o_eng_rvalid,
    output logic   o_eng_rdata
);

    localparam int unsigned DEPTH = 1 + RD_LATENCY;

    owner_t r_tag [DEPTH];
    logic   r_disp_hold;
    logic   r_eng_hold;

    // Tag shift register; the last stage lines up with valid RAM data
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_tag[i] <= OWN_NONE;
        end else begin
            r_tag[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    // Keep the last returned bit per requester between returns
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            r_disp_hold <= 1'b0;
            r_eng_hold  <= 1'b0;
        end else begin
            if (r_tag[DEPTH-1] == OWN_DISP) r_disp_hold <= i_rdata;
            if (r_tag[DEPTH-1] == OWN_ENG)  r_eng_hold  <= i_rdata;
        end
    end

    assign o_disp_rvalid = (r_tag[DEPTH-1] == OWN_DISP);
    assign o_eng_rvalid  = (r_tag[DEPTH-1] == OWN_ENG);
    assign o_disp_rdata  = o_disp_rvalid ? i_rdata : r_disp_hold;
    assign o_eng_rdata   = o_eng_rvalid  ? i_rdata : r_eng_hold;

endmodule

// File: rtl/grid_ram_arbiter.sv
// Shares the 1-bit grid RAM between display, pattern loader and life engine.
module grid_ram_arbiter
    import grid_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk_ram,
    input  logic              reset,
    grid_ram_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    mode_t             r_mode;
    mode_t             w_mode_nxt;
    logic [CNT_W-1:0]  r_ld_starve;
    logic [CNT_W-1:0]  r_eng_starve;
    logic              w_ld_ok;
    logic              w_eng_ok;
    logic              w_disp_gnt;
    logic              w_ld_gnt;
    logic              w_eng_gnt;
    owner_t            w_tag;
    logic [ADDR_W-1:0] r_ram_address;
    logic              r_ram_rden;
    logic              r_ram_wren;
    logic              r_ram_wdata;

    // Mode state register
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) r_mode <= MODE_IDLE;
        else       r_mode <= w_mode_nxt;
    end

    // Mode next-state: loading and running are mutually exclusive
    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            MODE_IDLE: begin
                if (bus.load_start)  w_mode_nxt = MODE_LOAD;
                else if (bus.run_en) w_mode_nxt = MODE_RUN;
            end
            MODE_RUN: begin
                if (bus.load_start)   w_mode_nxt = MODE_LOAD;
                else if (!bus.run_en) w_mode_nxt = MODE_IDLE;
            end
            MODE_LOAD: begin
                if (bus.load_done) w_mode_nxt = bus.run_en ? MODE_RUN : MODE_IDLE;
            end
            default: w_mode_nxt = MODE_IDLE;
        endcase
    end

    assign w_ld_ok  = bus.ld_req  && (r_mode == MODE_LOAD);
    assign w_eng_ok = bus.eng_req && (r_mode == MODE_RUN);

    // One grant per cycle; a starved eligible requester overrides display
    always_comb begin
        w_disp_gnt = 1'b0;
        w_ld_gnt   = 1'b0;
        w_eng_gnt  = 1'b0;
        if (!reset) begin
            if (w_ld_ok && (r_ld_starve == CNT_MAX))        w_ld_gnt   = 1'b1;
            else if (w_eng_ok && (r_eng_starve == CNT_MAX)) w_eng_gnt  = 1'b1;
            else if (bus.disp_req)                          w_disp_gnt = 1'b1;
            else if (w_ld_ok)                               w_ld_gnt   = 1'b1;
            else if (w_eng_ok)                              w_eng_gnt  = 1'b1;
        end
    end

    assign bus.disp_gnt = w_disp_gnt;
    assign bus.ld_gnt   = w_ld_gnt;
    assign bus.eng_gnt  = w_eng_gnt;
    assign bus.mode     = r_mode;

    // Starvation counters: count eligible denied cycles, saturating
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            r_ld_starve  <= '0;
            r_eng_starve <= '0;
        end else begin
            if (!bus.ld_req || w_ld_gnt)
                r_ld_starve <= '0;
            else if (w_ld_ok && (r_ld_starve != CNT_MAX))
                r_ld_starve <= r_ld_starve + CNT_W'(1);

            if (!bus.eng_req || w_eng_gnt)
                r_eng_starve <= '0;
            else if (w_eng_ok && (r_eng_starve != CNT_MAX))
                r_eng_starve <= r_eng_starve + CNT_W'(1);
        end
    end

    // Registered RAM command from the granted requester
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            r_ram_address <= '0;
            r_ram_rden    <= 1'b0;
            r_ram_wren    <= 1'b0;
            r_ram_wdata   <= 1'b0;
        end else begin
            r_ram_rden <= w_disp_gnt || (w_eng_gnt && !bus.eng_we);
            r_ram_wren <= w_ld_gnt   || (w_eng_gnt &&  bus.eng_we);
            if (w_disp_gnt) begin
                r_ram_address <= bus.disp_addr;
            end else if (w_ld_gnt) begin
                r_ram_address <= bus.ld_addr;
                r_ram_wdata   <= bus.ld_wdata;
            end else if (w_eng_gnt) begin
                r_ram_address <= bus.eng_addr;
                if (bus.eng_we) r_ram_wdata <= bus.eng_wdata;
            end
        end
    end

    assign bus.ram_address    = r_ram_address;
    assign bus.ram_rden       = r_ram_rden;
    assign bus.ram_wren       = r_ram_wren;
    assign bus.ram_write_data = r_ram_wdata;

    // Return tag for the read issued this cycle
    always_comb begin
        w_tag = OWN_NONE;
        if (w_disp_gnt)                    w_tag = OWN_DISP;
        else if (w_eng_gnt && !bus.eng_we) w_tag = OWN_ENG;
    end

    ram_return_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_return_pipe (
        .clk_ram       (clk_ram),
        .reset         (reset),
        .i_tag         (w_tag),
        .i_rdata       (bus.ram_read_data),
        .o_disp_rvalid (bus.disp_rvalid),
        .o_disp_rdata  (bus.disp_rdata),
        .o_eng_rvalid  (bus.eng_rvalid),
        .o_eng_rdata   (bus.eng_rdata)
    );

endmodule

// File: tb/tb_grid_ram_arbiter.sv
// Directed bench for grid_ram_arbiter with a small 2-cycle-latency RAM model.
module tb_grid_ram_arbiter;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [63:0] mem;
    logic [1:0]  rd_pipe;

    grid_ram_arbiter_if #(.ADDR_W(24)) bus ();

    grid_ram_arbiter #(
        .ADDR_W     (24),
        .RD_LATENCY (2),
        .STARVE_MAX (8)
    ) dut (
        .clk_ram (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data valid two cycles after rden is seen on the RAM pins
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_address[5:0]] <= bus.ram_write_data;
        rd_pipe[0] <= bus.ram_rden ? mem[bus.ram_address[5:0]] : 1'b0;
        rd_pipe[1] <= rd_pipe[0];
    end
    assign bus.ram_read_data = rd_pipe[1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.load_start = 0; bus.load_done = 0; bus.run_en = 0;
        bus.disp_req = 1; bus.disp_addr = '0;
        bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = 0;
        bus.eng_req = 0; bus.eng_we = 0; bus.eng_addr = '0; bus.eng_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.mode, bus.disp_gnt, bus.ld_gnt, bus.eng_gnt} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mode_gnt: got %b expected 00000", {bus.mode, bus.disp_gnt, bus.ld_gnt, bus.eng_gnt});
        end
        n_tests++;
        if ({bus.ram_address, bus.ram_rden, bus.ram_wren, bus.ram_write_data} !== 27'b0) begin
            n_fail++; $display("FAIL reset_ram: got %h expected 0", {bus.ram_address, bus.ram_rden, bus.ram_wren, bus.ram_write_data});
        end
        n_tests++;
        if ({bus.disp_rvalid, bus.disp_rdata, bus.eng_rvalid, bus.eng_rdata} !== 4'b0) begin
            n_fail++; $display("FAIL reset_rvalid: got %b expected 0000", {bus.disp_rvalid, bus.disp_rdata, bus.eng_rvalid, bus.eng_rdata});
        end
        bus.disp_req = 0;
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_load_writes();
        logic [3:0] pat;
        pat = 4'b1101;
        bus.load_start = 1;
        next_cycle();
        bus.load_start = 0;
        for (int i = 0; i < 4; i++) begin
            bus.ld_req = 1; bus.ld_addr = 24'(i); bus.ld_wdata = pat[i];
            @(negedge clk);
            n_tests++;
            if ({bus.mode, bus.ld_gnt, bus.disp_gnt} !== 4'b0110) begin
                n_fail++; $display("FAIL load_gnt[%0d]: got %b expected 0110", i, {bus.mode, bus.ld_gnt, bus.disp_gnt});
            end
            if (i > 0) begin
                n_tests++;
                if ({bus.ram_wren, bus.ram_rden, bus.ram_write_data, bus.ram_address} !== {2'b10, pat[i-1], 24'(i-1)}) begin
                    n_fail++; $display("FAIL load_ram[%0d]: got %h expected %h", i - 1,
                        {bus.ram_wren, bus.ram_rden, bus.ram_write_data, bus.ram_address}, {2'b10, pat[i-1], 24'(i-1)});
                end
            end
            next_cycle();
        end
        bus.ld_req = 0;
        @(negedge clk);
        n_tests++;
        if ({bus.ld_gnt, bus.ram_wren, bus.ram_rden, bus.ram_write_data, bus.ram_address} !== {4'b0101, 24'd3}) begin
            n_fail++; $display("FAIL load_last: got %h expected %h",
                {bus.ld_gnt, bus.ram_wren, bus.ram_rden, bus.ram_write_data, bus.ram_address}, {4'b0101, 24'd3});
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({bus.ram_wren, bus.ram_rden, bus.ram_address} !== {2'b00, 24'd3}) begin
            n_fail++; $display("FAIL load_hold: got %h expected %h", {bus.ram_wren, bus.ram_rden, bus.ram_address}, {2'b00, 24'd3});
        end
        next_cycle();
    endtask

    task automatic test_starve();
        logic [1:0] exp;
        bus.disp_req = 1; bus.disp_addr = 24'd20;
        bus.ld_req = 1; bus.ld_addr = 24'd10; bus.ld_wdata = 0;
        for (int c = 0; c < 20; c++) begin
            exp = ((c % 9) == 8) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_tests++;
            if ({bus.disp_gnt, bus.ld_gnt} !== exp) begin
                n_fail++; $display("FAIL starve[%0d]: got %b expected %b", c, {bus.disp_gnt, bus.ld_gnt}, exp);
            end
            next_cycle();
        end
        bus.disp_req = 0; bus.ld_req = 0;
        bus.load_done = 1; bus.run_en = 1;
        next_cycle();
        bus.load_done = 0;
        @(negedge clk);
        n_tests++;
        if (bus.mode !== 2'd2) begin
            n_fail++; $display("FAIL load_to_run: got %0d expected 2", bus.mode);
        end
        next_cycle();
    endtask

    task automatic test_eng_reads();
        bus.eng_req = 1; bus.eng_we = 1; bus.eng_addr = 24'd5; bus.eng_wdata = 1;
        @(negedge clk);
        n_tests++;
        if (bus.eng_gnt !== 1'b1) begin
            n_fail++; $display("FAIL eng_wr_gnt: got %b expected 1", bus.eng_gnt);
        end
        next_cycle();
        bus.eng_addr = 24'd6; bus.eng_wdata = 0;
        @(negedge clk);
        n_tests++;
        if ({bus.eng_gnt, bus.ram_wren, bus.ram_rden, bus.ram_write_data, bus.ram_address} !== {4'b1101, 24'd5}) begin
            n_fail++; $display("FAIL eng_wr_ram: got %h expected %h",
                {bus.eng_gnt, bus.ram_wren, bus.ram_rden, bus.ram_write_data, bus.ram_address}, {4'b1101, 24'd5});
        end
        next_cycle();
        bus.eng_we = 0; bus.eng_addr = 24'd5;
        @(negedge clk);
        n_tests++;
        if (bus.eng_gnt !== 1'b1) begin
            n_fail++; $display("FAIL eng_rd_gnt0: got %b expected 1", bus.eng_gnt);
        end
        next_cycle();
        bus.eng_addr = 24'd6;
        @(negedge clk);
        n_tests++;
        if ({bus.eng_gnt, bus.ram_rden, bus.ram_wren, bus.ram_address} !== {3'b110, 24'd5}) begin
            n_fail++; $display("FAIL eng_rd_gnt1: got %h expected %h", {bus.eng_gnt, bus.ram_rden, bus.ram_wren, bus.ram_address}, {3'b110, 24'd5});
        end
        next_cycle();
        bus.eng_req = 0;
        @(negedge clk);
        n_tests++;
        if (bus.eng_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL eng_rv_early: got %b expected 0", bus.eng_rvalid);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({bus.eng_rvalid, bus.eng_rdata, bus.disp_rvalid} !== 3'b110) begin
            n_fail++; $display("FAIL eng_rd5: got %b expected 110", {bus.eng_rvalid, bus.eng_rdata, bus.disp_rvalid});
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({bus.eng_rvalid, bus.eng_rdata, bus.disp_rvalid} !== 3'b100) begin
            n_fail++; $display("FAIL eng_rd6: got %b expected 100", {bus.eng_rvalid, bus.eng_rdata, bus.disp_rvalid});
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({bus.eng_rvalid, bus.eng_rdata} !== 2'b00) begin
            n_fail++; $display("FAIL eng_rd_after: got %b expected 00", {bus.eng_rvalid, bus.eng_rdata});
        end
        next_cycle();
    endtask

    task automatic test_idle_block();
        logic [2:0] exp;
        bus.run_en = 0;
        next_cycle();
        bus.disp_req = 1; bus.disp_addr = 24'd30;
        bus.ld_req = 1; bus.ld_addr = 24'd12; bus.ld_wdata = 1;
        bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 24'd7;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.mode, bus.disp_gnt, bus.ld_gnt, bus.eng_gnt} !== 5'b00100) begin
                n_fail++; $display("FAIL idle_gnt[%0d]: got %b expected 00100", c, {bus.mode, bus.disp_gnt, bus.ld_gnt, bus.eng_gnt});
            end
            next_cycle();
        end
        bus.load_start = 1;
        next_cycle();
        bus.load_start = 0;
        for (int c = 0; c < 9; c++) begin
            exp = (c == 8) ? 3'b010 : 3'b100;
            @(negedge clk);
            n_tests++;
            if ({bus.mode, bus.disp_gnt, bus.ld_gnt, bus.eng_gnt} !== {2'b01, exp}) begin
                n_fail++; $display("FAIL idle_cnt[%0d]: got %b expected %b", c, {bus.mode, bus.disp_gnt, bus.ld_gnt, bus.eng_gnt}, {2'b01, exp});
            end
            next_cycle();
        end
        bus.disp_req = 0; bus.ld_req = 0; bus.eng_req = 0;
        bus.load_done = 1; bus.run_en = 1;
        next_cycle();
        bus.load_done = 0;
        next_cycle();
    endtask

    task automatic test_mode_change_inflight();
        bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 24'd0;
        @(negedge clk);
        n_tests++;
        if ({bus.mode, bus.eng_gnt} !== 3'b101) begin
            n_fail++; $display("FAIL mc_gnt: got %b expected 101", {bus.mode, bus.eng_gnt});
        end
        next_cycle();
        bus.eng_req = 0; bus.load_start = 1;
        next_cycle();
        bus.load_start = 0; bus.eng_req = 1; bus.eng_addr = 24'd1;
        @(negedge clk);
        n_tests++;
        if ({bus.mode, bus.eng_gnt, bus.eng_rvalid} !== 4'b0100) begin
            n_fail++; $display("FAIL mc_load: got %b expected 0100", {bus.mode, bus.eng_gnt, bus.eng_rvalid});
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({bus.eng_gnt, bus.eng_rvalid, bus.eng_rdata} !== 3'b011) begin
            n_fail++; $display("FAIL mc_return: got %b expected 011", {bus.eng_gnt, bus.eng_rvalid, bus.eng_rdata});
        end
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.mode, bus.eng_gnt, bus.eng_rvalid} !== 4'b0100) begin
                n_fail++; $display("FAIL mc_blocked[%0d]: got %b expected 0100", c, {bus.mode, bus.eng_gnt, bus.eng_rvalid});
            end
            next_cycle();
        end
        bus.load_done = 1;
        next_cycle();
        bus.load_done = 0;
        @(negedge clk);
        n_tests++;
        if ({bus.mode, bus.eng_gnt} !== 3'b101) begin
            n_fail++; $display("FAIL mc_resume: got %b expected 101", {bus.mode, bus.eng_gnt});
        end
        next_cycle();
        bus.eng_req = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.eng_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL mc_wait[%0d]: got %b expected 0", c, bus.eng_rvalid);
            end
            next_cycle();
        end
        @(negedge clk);
        n_tests++;
        if ({bus.eng_rvalid, bus.eng_rdata} !== 2'b10) begin
            n_fail++; $display("FAIL mc_rd1: got %b expected 10", {bus.eng_rvalid, bus.eng_rdata});
        end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        bus.run_en = 0;
        bus.disp_req = 1; bus.disp_addr = 24'd3;
        @(negedge clk);
        n_tests++;
        if (bus.disp_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rst_gnt: got %b expected 1", bus.disp_gnt);
        end
        next_cycle();
        bus.disp_req = 0;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.mode, bus.disp_gnt, bus.ram_rden, bus.ram_wren, bus.ram_write_data, bus.ram_address} !== 30'b0) begin
            n_fail++; $display("FAIL rst_async: got %h expected 0",
                {bus.mode, bus.disp_gnt, bus.ram_rden, bus.ram_wren, bus.ram_write_data, bus.ram_address});
        end
        next_cycle();
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.disp_rvalid, bus.disp_rdata, bus.eng_rvalid} !== 3'b000) begin
                n_fail++; $display("FAIL rst_drop[%0d]: got %b expected 000", c, {bus.disp_rvalid, bus.disp_rdata, bus.eng_rvalid});
            end
            next_cycle();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mem     = '0;
        rd_pipe = '0;
        test_reset();
        test_load_writes();
        test_starve();
        test_eng_reads();
        test_idle_block();
        test_mode_change_inflight();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_ram_arbiter.md
Name: grid_ram_arbiter

Overview:
- Shares the single 1-bit-wide grid RAM between three requesters:
  - display scanout (VGA pixel fetch), read only;
  - SD pattern loader, write only;
  - life update engine, read/write.
- Sits between those masters and the RAM on the clk_ram domain.
- Holds a mode state machine (IDLE/LOAD/RUN) so that loading a new pattern and running generations never touch RAM concurrently.
- Routes read data back to whichever requester issued each read.

Parameters:
- ADDR_W, 24, RAM address width
- RD_LATENCY, 2, RAM cycles from registered rden to valid ram_read_data (1..4)
- STARVE_MAX, 8, consecutive denied cycles before a non-display requester overrides display priority

Ports:
- clk_ram  input  1  RAM clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- load_start  input  1  pulse: enter LOAD (pattern load about to begin)
- load_done  input  1  level from loader (its read_file_finish)
- run_en  input  1  level: engine allowed to run when not loading
- mode  output  2  0=IDLE, 1=LOAD, 2=RUN
- disp_req  input  1  display read request
- disp_addr  input  ADDR_W  display address
- disp_gnt  output  1  display request accepted this cycle
- disp_rvalid  output  1  display read data valid
- disp_rdata  output  1  display read data
- ld_req  input  1  loader write request
- ld_addr  input  ADDR_W  loader address
- ld_wdata  input  1  loader write bit
- ld_gnt  output  1  loader request accepted this cycle
- eng_req  input  1  engine request
- eng_we  input  1  engine write (1) / read (0)
- eng_addr  input  ADDR_W  engine address
- eng_wdata  input  1  engine write bit
- eng_gnt  output  1  engine request accepted this cycle
- eng_rvalid  output  1  engine read data valid
- eng_rdata  output  1  engine read data
- ram_address  output  ADDR_W  RAM address (registered)
- ram_rden  output  1  RAM read enable (registered)
- ram_wren  output  1  RAM write enable (registered)
- ram_write_data  output  1  RAM write bit (registered)
- ram_read_data  input  1  RAM read bit

Behaviour:
- Reset values:
  - mode=IDLE;
  - all gnt, rvalid, rdata, ram_rden, ram_wren, ram_write_data = 0;
  - ram_address = 0;
  - starvation counters and the return-tag pipeline are cleared.
- Reset asserted mid-operation drops all in-flight reads; no rvalid is ever produced for them.
- Mode FSM (registered):
  - IDLE -> LOAD on load_start;
  - IDLE -> RUN on run_en && !load_start;
  - RUN -> LOAD on load_start (load_start has priority);
  - RUN -> IDLE on !run_en;
  - LOAD -> RUN when load_done && run_en;
  - LOAD -> IDLE when load_done && !run_en;
  - load_start while already in LOAD is ignored.
- Eligibility by mode:
  - display is eligible in every mode;
  - loader is eligible only in LOAD;
  - engine is eligible only in RUN;
  - a request from an ineligible requester is never granted and does not advance its starvation counter.
- Arbitration (combinational, same cycle as req; exactly one grant per cycle at most):
  - default priority is display > loader > engine;
  - if the eligible non-display requester's starve counter == STARVE_MAX, it wins over display that cycle.
- Starve counters:
  - increment when requesting, eligible and not granted;
  - clear when granted or when req is low;
  - saturate at STARVE_MAX.
- Requester handshake: a requester holds req/addr/data stable until it sees gnt high; the transfer completes on that edge.
- Command register: the granted command appears on ram_* the next cycle. ram_rden and ram_wren are never both 1. With no grant, both are 0 and address/data hold.
- Read return:
  - a tag (none/display/engine) shift register of depth 1+RD_LATENCY tracks each read;
  - xx_rvalid pulses for one cycle exactly 1+RD_LATENCY cycles after the gnt cycle, with xx_rdata = ram_read_data;
  - rdata holds its last value otherwise.
  - Back-to-back reads are fully pipelined (one per cycle).
- Mode change with reads in flight: reads already granted still return to their tag; there is no drain stall.
- Writes complete with no acknowledgement beyond gnt.
- Same-cycle read and write to the same address cannot occur (one grant per cycle). Read-after-write ordering follows grant order.

Decomposition:
- Shared package grid_pkg holds:
  - mode_t enum (MODE_IDLE, MODE_LOAD, MODE_RUN);
  - owner_t enum (OWN_NONE, OWN_DISP, OWN_ENG) used for return tags;
  - ADDR_W default.
- One natural sub-module: ram_return_pipe, the tag/valid shift register of depth 1+RD_LATENCY that demuxes ram_read_data into the per-requester rvalid/rdata.

Test Plan:
- Reset then load_start pulse, ld_req with ld_addr=0..3, ld_wdata=1,0,1,1 and disp_req low → ld_gnt every cycle; ram_wren=1 one cycle later with matching address/data; mode=1.
- LOAD mode, disp_req and ld_req both held high for 20 cycles, STARVE_MAX=8 → display wins 8 consecutive cycles, then loader wins on the 9th; the pattern repeats.
- RUN mode (run_en=1), eng_req reads at addresses 5 and 6 back-to-back with RAM holding 1 and 0 → eng_rvalid on cycles gnt+3 and gnt+4, eng_rdata 1 then 0 (RD_LATENCY=2).
- IDLE mode, ld_req and eng_req held high → never granted, counters stay 0; disp_req is granted every cycle.
- RUN mode with an engine read in flight, load_start asserted → mode=LOAD next cycle; the in-flight read still returns on eng_rvalid; eng_gnt is 0 afterwards until load_done && run_en gives mode=RUN.
- Reset asserted one cycle after a display read grant → no disp_rvalid ever appears; all outputs are 0 and mode=IDLE immediately (asynchronous).
